// File: rtl/dsp_pipe_pkg.sv
// Shared constants and helpers for the dsp_pipe operand pipeline.
package dsp_pipe_pkg;

  localparam int MAX_DEPTH = 4;

  // Taps beyond the last instantiated stage read the last stage.
  function automatic int tap_clamp(input int tap, input int depth);
    return (tap > depth) ? depth : tap;
  endfunction

  function automatic int occ_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dsp_pipe_stage.sv
// One operand pipeline stage: data register plus valid bit, priority rst > flush > ce.
module dsp_pipe_stage
  import dsp_pipe_pkg::*;
#(
  parameter int               WIDTH   = 18,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  // Flush only clears the valid bit; data keeps shifting when ce is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= RST_VAL;
      dout_valid <= 1'b0;
    end else begin
      if (ce) dout <= din;
      if (flush)   dout_valid <= 1'b0;
      else if (ce) dout_valid <= din_valid;
    end
  end

endmodule

// File: rtl/dsp_pipe_reg.sv
// DEPTH-stage operand pipeline with runtime output tap (0 = bypass).
// Optional occupancy counter output enabled by macro DSP_PIPE_OCC_EN.
module dsp_pipe_reg
  import dsp_pipe_pkg::*;
#(
  parameter int               WIDTH   = 18,
  parameter int               DEPTH   = 2,
  parameter int               TAP_W   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ce,
  input  logic                          flush,
  input  logic [WIDTH-1:0]              din,
  input  logic                          din_valid,
  input  logic [TAP_W-1:0]              tap,
`ifdef DSP_PIPE_OCC_EN
  output logic [occ_w(MAX_DEPTH)-1:0]   occ,
`endif
  output logic [WIDTH-1:0]              dout,
  output logic                          dout_valid
);

  localparam int SEL_W = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1);

  // Index 0 of the chain is the bypass path, index k is the output of stage k.
  logic [WIDTH-1:0] d_chain [0:DEPTH];
  logic [DEPTH:0]   v_chain;
  logic [SEL_W-1:0] sel;

  assign d_chain[0] = din;
  assign v_chain[0] = din_valid;

  genvar k;
  generate
    for (k = 1; k <= DEPTH; k++) begin : g_stage
      dsp_pipe_stage #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .flush      (flush),
        .din        (d_chain[k-1]),
        .din_valid  (v_chain[k-1]),
        .dout       (d_chain[k]),
        .dout_valid (v_chain[k])
      );
    end
  endgenerate

  assign sel        = SEL_W'(tap_clamp(int'(tap), DEPTH));
  assign dout       = d_chain[sel];
  assign dout_valid = v_chain[sel];

`ifdef DSP_PIPE_OCC_EN
  localparam int OCC_W = occ_w(MAX_DEPTH);

  generate
    if (DEPTH == 0) begin : g_occ_none
      assign occ = '0;
    end else begin : g_occ
      logic [OCC_W-1:0] occ_q;

      // Incremental count: one entry in from din, one out from the last stage.
      always_ff @(posedge clk) begin
        if (rst || flush) occ_q <= '0;
        else if (ce)      occ_q <= occ_q + OCC_W'(din_valid) - OCC_W'(v_chain[DEPTH]);
      end

      assign occ = occ_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_dsp_pipe_reg.sv
// Self-checking bench for dsp_pipe_reg: DEPTH=2 instance plus a DEPTH=0 bypass instance.
module tb_dsp_pipe_reg;
  import dsp_pipe_pkg::*;

  localparam int          WIDTH = 18;
  localparam logic [17:0] RV    = 18'h30000;

  logic              clk = 1'b0;
  logic              rst, ce, flush, din_valid;
  logic [WIDTH-1:0]  din;
  logic [2:0]        tap;
  logic [WIDTH-1:0]  dout, dout0;
  logic              dout_valid, dout_valid0;
`ifdef DSP_PIPE_OCC_EN
  logic [occ_w(MAX_DEPTH)-1:0] occ, occ0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit sb_en = 1'b0;
  logic [WIDTH-1:0] sb_q [$];

  always #5 clk = ~clk;

  dsp_pipe_reg #(.WIDTH(WIDTH), .DEPTH(2), .TAP_W(3), .RST_VAL(RV)) u_dut (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .din(din), .din_valid(din_valid), .tap(tap),
`ifdef DSP_PIPE_OCC_EN
    .occ(occ),
`endif
    .dout(dout), .dout_valid(dout_valid)
  );

  dsp_pipe_reg #(.WIDTH(WIDTH), .DEPTH(0), .TAP_W(3), .RST_VAL(RV)) u_dut0 (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .din(din), .din_valid(din_valid), .tap(tap),
`ifdef DSP_PIPE_OCC_EN
    .occ(occ0),
`endif
    .dout(dout0), .dout_valid(dout_valid0)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_occ(input string tag, input int exp);
`ifdef DSP_PIPE_OCC_EN
    check(tag, 32'(occ), exp);
`endif
  endtask

  // Settle, run the scoreboard on the cycle's inputs, then take the clock edge.
  task automatic step();
    #1;
    if (sb_en) begin
      if (rst) sb_q.delete();
      else begin
        if (ce && dout_valid) begin
          check("sb_nonempty", 32'(sb_q.size() != 0), 1);
          if (sb_q.size() != 0) check("sb_data", 32'(dout), 32'(sb_q.pop_front()));
        end
        if (flush) sb_q.delete();
        else if (ce && din_valid) sb_q.push_back(din);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_d;
    logic        exp_v;

    // Reset
    rst = 1'b1; ce = 1'b1; flush = 1'b0; din = 18'h155; din_valid = 1'b1; tap = 3'd2;
    step(); step();
    rst = 1'b0; ce = 1'b0;
    #1;
    check("rst_dout_t2", 32'(dout), 32'(RV));
    check("rst_vld_t2", 32'(dout_valid), 0);
    check_occ("rst_occ", 0);
    tap = 3'd1; #1;
    check("rst_dout_t1", 32'(dout), 32'(RV));
    check("rst_vld_t1", 32'(dout_valid), 0);
    tap = 3'd0; #1;
    check("rst_bypass", 32'(dout), 32'h155);

    // Latency sweep across taps, including clamped taps
    ce = 1'b1; din_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      din = 18'(c + 1);
      tap = 3'd0; #1;
      check("lat_t0_d", 32'(dout), c + 1);
      check("lat_t0_v", 32'(dout_valid), 1);
      tap = 3'd1; #1;
      exp_d = (c < 1) ? 32'(RV) : 32'(c);
      check("lat_t1_d", 32'(dout), exp_d);
      check("lat_t1_v", 32'(dout_valid), (c >= 1) ? 1 : 0);
      exp_d = (c < 2) ? 32'(RV) : 32'(c - 1);
      exp_v = (c >= 2);
      for (int t = 2; t < 8; t += 3) begin
        tap = 3'(t); #1;
        check($sformatf("lat_t%0d_d", t), 32'(dout), exp_d);
        check($sformatf("lat_t%0d_v", t), 32'(dout_valid), 32'(exp_v));
      end
      check_occ("lat_occ", (c > 2) ? 2 : c);
      step();
    end

    // Simultaneous rst + flush + ce: reset wins
    rst = 1'b1; flush = 1'b1; ce = 1'b1; din = 18'h77; din_valid = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; ce = 1'b0;
    for (int t = 1; t <= 2; t++) begin
      tap = 3'(t); #1;
      check("rfc_dout", 32'(dout), 32'(RV));
      check("rfc_vld", 32'(dout_valid), 0);
    end
    check_occ("rfc_occ", 0);

    // Stall with scoreboard ordering
    tap = 3'd2; sb_en = 1'b1; ce = 1'b1; din_valid = 1'b1;
    din = 18'hA; step();
    din = 18'hB; step();
    ce = 1'b0; din = 18'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_dout", 32'(dout), 32'hA);
      check("stall_vld", 32'(dout_valid), 1);
      check_occ("stall_occ", 2);
      step();
    end
    ce = 1'b1; din_valid = 1'b0;
    #1;
    check("resume_a", 32'(dout), 32'hA);
    step();
    check("resume_b", 32'(dout), 32'hB);
    step();
    for (int i = 0; i < 24; i++) begin
      din = 18'($urandom);
      din_valid = 1'($urandom);
      ce = ($urandom_range(0, 3) != 0);
      step();
    end
    ce = 1'b1; din_valid = 1'b0;
    step(); step(); step();
    check("sb_drained", 32'(sb_q.size()), 0);
    sb_en = 1'b0;

    // Flush while ce=1: valids clear, data still shifts
    din_valid = 1'b1;
    din = 18'h11; step();
    din = 18'h22; step();
    din = 18'h33; flush = 1'b1; step();
    flush = 1'b0; ce = 1'b0;
    tap = 3'd1; #1;
    check("fl_t1_d", 32'(dout), 32'h33);
    check("fl_t1_v", 32'(dout_valid), 0);
    tap = 3'd2; #1;
    check("fl_t2_d", 32'(dout), 32'h22);
    check("fl_t2_v", 32'(dout_valid), 0);
    check_occ("fl_occ", 0);
    ce = 1'b1; din = 18'h44; step();
    tap = 3'd1; #1;
    check("fl_next_t1_v", 32'(dout_valid), 1);
    tap = 3'd2; #1;
    check("fl_next_t2_d", 32'(dout), 32'h33);
    check("fl_next_t2_v", 32'(dout_valid), 0);
    check_occ("fl_next_occ", 1);

    // Flush while stalled: data holds, valids clear
    din = 18'h55; step();
    flush = 1'b1; ce = 1'b0; din = 18'h66; step();
    flush = 1'b0;
    tap = 3'd1; #1;
    check("fls_t1_d", 32'(dout), 32'h55);
    check("fls_t1_v", 32'(dout_valid), 0);
    tap = 3'd2; #1;
    check("fls_t2_d", 32'(dout), 32'h44);
    check("fls_t2_v", 32'(dout_valid), 0);
    check_occ("fls_occ", 0);

    // DEPTH=0 instance is a pure bypass under random controls
    for (int i = 0; i < 30; i++) begin
      din = 18'($urandom);
      din_valid = 1'($urandom);
      tap = 3'($urandom);
      ce = 1'($urandom);
      flush = 1'($urandom);
      rst = ($urandom_range(0, 4) == 0);
      #1;
      check("d0_dout", 32'(dout0), 32'(din));
      check("d0_vld", 32'(dout_valid0), 32'(din_valid));
`ifdef DSP_PIPE_OCC_EN
      check("d0_occ", 32'(occ0), 0);
`endif
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
